hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage F/D/E/M/W pipeline. Drives stall/flush
//  enables of the decode->execute and neighbouring pipeline registers, and the execute-stage
//  operand forwarding selects. Sequences multi-cycle data-memory waits and post-branch
//  redirect bubbles; keeps saturating stall/flush event counters for debug.
// PARAMETERS
//  REDIRECT_CYC  1   extra cycles flush_d held after a taken branch (fetch latency), 0..15
//  MAX_WAIT      64  memory-wait cycles before mem_timeout sets, >=1
//  CNT_W         16  width of stall_cnt/flush_cnt
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  ra1_d,ra2_d  in   4      decode-stage source registers
//  ra1_e,ra2_e  in   4      execute-stage source registers
//  wa3_e,wa3_m,wa3_w in 4   destination register in E/M/W
//  regwrite_e,regwrite_m,regwrite_w in 1  register write valid in E/M/W
//  memtoreg_e   in   1      E-stage instruction is a load
//  pcsrc_e      in   1      taken branch / PC write resolved in E
//  mem_req_m    in   1      M-stage memory access active
//  mem_ready    in   1      data memory completes access this cycle
//  fwd_a_e,fwd_b_e out 2    00 regfile, 01 from W result, 10 from M ALU result
//  stall_f,stall_d,stall_e,stall_m out 1  hold the stage's pipeline register
//  flush_d,flush_e out 1    clear D / E pipeline register to bubble (all controls 0)
//  state        out  2      00 RUN, 01 MEM_WAIT, 10 REDIRECT
//  mem_timeout  out  1      sticky: wait exceeded MAX_WAIT
//  stall_cnt,flush_cnt out CNT_W  saturating event counters
// BEHAVIOUR
//  Reset (async): state=RUN, redirect/wait counters=0, mem_timeout=0, stall_cnt=flush_cnt=0;
//   all stall/flush outputs 0, fwd selects 00 while reset high.
//  Forwarding (combinational, per operand X in {1,2}): 10 if regwrite_m && wa3_m==raX_e &&
//   wa3_m!=15; else 01 if regwrite_w && wa3_w==raX_e && wa3_w!=15; else 00. M beats W. R15 never forwarded.
//  lduse = memtoreg_e && regwrite_e && (wa3_e==ra1_d || wa3_e==ra2_d).
//  memblk = mem_req_m && !mem_ready.
//  Priority within a cycle: memblk > pcsrc_e > lduse.
//  RUN:
//   memblk -> stall_f/d/e/m=1, no flush; next MEM_WAIT, wait counter=1. pcsrc_e ignored
//    (E frozen, re-evaluated after release).
//   else pcsrc_e -> flush_d=flush_e=1, stalls 0; next REDIRECT with redirect counter=REDIRECT_CYC,
//    or stay RUN if REDIRECT_CYC==0. Branch+lduse same cycle: flush only, no stall.
//   else lduse -> stall_f=stall_d=1, flush_e=1 for exactly this cycle (one bubble); stay RUN.
//  MEM_WAIT: stall_f/d/e/m=1 while !mem_ready; wait counter++ (saturates at MAX_WAIT);
//   reaching MAX_WAIT sets mem_timeout (cleared only by reset). mem_ready=1 -> stalls drop
//   the same cycle, next RUN.
//  REDIRECT: flush_d=1, counter-- each cycle; counter==1 -> next RUN. memblk overrides
//   (stall, counter held, go MEM_WAIT-style freeze while staying in REDIRECT). New pcsrc_e
//   reloads counter and asserts flush_e.
//  stall_cnt += 1 each cycle stall_f=1; flush_cnt += 1 each cycle pcsrc_e flush taken;
//   both saturate at all-ones, no wrap.
//  Outputs are combinational from registered state and current inputs; zero added latency.
// TESTING
//  1 ALU chain: E ra1_e=3, M wa3_m=3 regwrite_m=1, W wa3_w=3 -> fwd_a_e=10; M off -> 01; wa3=15 -> 00.
//  2 Load-use: memtoreg_e=1 wa3_e=5, ra2_d=5 -> one cycle stall_f=stall_d=flush_e=1, then all 0.
//  3 Mem wait: mem_req_m=1, mem_ready=0 for 3 cycles then 1 -> stalls 1 for 3 cycles, 0 on
//    ready cycle, state 00->01->01->01->00, stall_cnt=3.
//  4 Branch: pcsrc_e=1, REDIRECT_CYC=1 -> flush_d=flush_e=1, next cycle flush_d=1 only, then RUN;
//    flush_cnt=1. Same with lduse=1 -> stall_f stays 0.
//  5 Timeout: MAX_WAIT=4, mem_ready held 0 -> mem_timeout=1 on 4th wait cycle, stays 1 after ready.
//  6 Reset asserted mid MEM_WAIT -> state=00, all outputs/counters 0 immediately, no clock needed.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the F/D/E/M/W pipeline.
// Sequences data-memory waits and post-branch redirect bubbles.
module hazard_ctrl #(
  parameter int REDIRECT_CYC = 1,
  parameter int MAX_WAIT     = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ra1_d,
  input  logic [3:0]       ra2_d,
  input  logic [3:0]       ra1_e,
  input  logic [3:0]       ra2_e,
  input  logic [3:0]       wa3_e,
  input  logic [3:0]       wa3_m,
  input  logic [3:0]       wa3_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             memtoreg_e,
  input  logic             pcsrc_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]    WMAX = WW'(MAX_WAIT);
  localparam logic [3:0]       RCYC = 4'(REDIRECT_CYC);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_MWAIT = 2'b01,
    S_REDIR = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [3:0]       r_redir;
  logic [3:0]       w_redir_nxt;
  logic [WW-1:0]    r_wait;
  logic [WW-1:0]    w_wait_nxt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_memblk;
  logic       w_lduse;
  logic       w_memstall;
  logic       w_br;
  logic       w_stall_fd;
  logic       w_stall_em;
  logic       w_flush_d;
  logic       w_flush_e;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_memblk = mem_req_m & ~mem_ready;
  assign w_lduse  = memtoreg_e & regwrite_e &
                    ((wa3_e == ra1_d) | (wa3_e == ra2_d));

  // Operand bypass: M-stage result wins over W; R15 is never bypassed.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (regwrite_m && wa3_m == ra1_e && wa3_m != 4'hF)
      w_fwd_a = 2'b10;
    else if (regwrite_w && wa3_w == ra1_e && wa3_w != 4'hF)
      w_fwd_a = 2'b01;
    if (regwrite_m && wa3_m == ra2_e && wa3_m != 4'hF)
      w_fwd_b = 2'b10;
    else if (regwrite_w && wa3_w == ra2_e && wa3_w != 4'hF)
      w_fwd_b = 2'b01;
  end

  // Next-state and stall/flush decode: memory freeze > branch > load-use.
  always_comb begin
    w_nstate    = r_state;
    w_redir_nxt = r_redir;
    w_stall_fd  = 1'b0;
    w_stall_em  = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_br        = 1'b0;
    w_memstall  = (r_state == S_MWAIT) ? ~mem_ready : w_memblk;
    if (w_memstall) begin
      w_stall_fd = 1'b1;
      w_stall_em = 1'b1;
      if (r_state == S_RUN)
        w_nstate = S_MWAIT;
    end else if (pcsrc_e) begin
      w_flush_d   = 1'b1;
      w_flush_e   = 1'b1;
      w_br        = 1'b1;
      w_redir_nxt = RCYC;
      w_nstate    = (RCYC == 4'd0) ? S_RUN : S_REDIR;
    end else if (r_state == S_REDIR) begin
      w_flush_d   = 1'b1;
      w_redir_nxt = r_redir - 4'd1;
      if (r_redir <= 4'd1)
        w_nstate = S_RUN;
    end else begin
      w_nstate = S_RUN;
      if (w_lduse) begin
        w_stall_fd = 1'b1;
        w_flush_e  = 1'b1;
      end
    end
    if (reset) begin
      w_stall_fd = 1'b0;
      w_stall_em = 1'b0;
      w_flush_d  = 1'b0;
      w_flush_e  = 1'b0;
      w_br       = 1'b0;
      w_memstall = 1'b0;
    end
  end

  // Consecutive memory-freeze cycles, saturating at MAX_WAIT.
  always_comb begin
    w_wait_nxt = '0;
    if (w_memstall)
      w_wait_nxt = (r_wait >= WMAX) ? r_wait : r_wait + 1'b1;
  end

  // State, redirect/wait counters, sticky timeout and event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_redir     <= '0;
      r_wait      <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_nstate;
      r_redir <= w_redir_nxt;
      r_wait  <= w_wait_nxt;
      if (w_memstall && w_wait_nxt == WMAX)
        r_timeout <= 1'b1;
      if (w_stall_fd && r_stall_cnt != CMAX)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br && r_flush_cnt != CMAX)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign fwd_a_e     = reset ? 2'b00 : w_fwd_a;
  assign fwd_b_e     = reset ? 2'b00 : w_fwd_b;
  assign stall_f     = w_stall_fd;
  assign stall_d     = w_stall_fd;
  assign stall_e     = w_stall_em;
  assign stall_m     = w_stall_em;
  assign flush_d     = w_flush_d;
  assign flush_e     = w_flush_e;
  assign state       = r_state;
  assign mem_timeout = r_timeout;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
